fbcpu_acc_core: RTL and testbench

- Parametrised second-generation accumulator CPU core for the FB-CPU family.
- Fetches single-word instructions from external single-port RAM and executes an extended 4-bit opcode set: load/store, ALU, jumps, immediate, halt.
- Supports arbitrary data/address widths, a Z/N/C flag register, a multi-cycle iterative divider, and a HALT state with external resume.
- Sits between the RAM model and the top-level/testbench, in place of the fixed-width core.

---
 rtl/fbcpu_pkg.sv | 38 +++
 rtl/fbcpu_divider.sv | 65 ++++++
 rtl/fbcpu_acc_core.sv | 184 ++++++++++++++++++
 tb/tb_fbcpu_acc_core.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fbcpu_pkg.sv
// Shared definitions for the FB-CPU accumulator core: opcodes, FSM states, flag bit positions.
package fbcpu_pkg;

  localparam logic [3:0] OP_LOAD  = 4'd0;
  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_MUL   = 4'd4;
  localparam logic [3:0] OP_DIV   = 4'd5;
  localparam logic [3:0] OP_JMP   = 4'd6;
  localparam logic [3:0] OP_JZ    = 4'd7;
  localparam logic [3:0] OP_NOP   = 4'd8;
  localparam logic [3:0] OP_HALT  = 4'd9;
  localparam logic [3:0] OP_AND   = 4'd10;
  localparam logic [3:0] OP_OR    = 4'd11;
  localparam logic [3:0] OP_LDI   = 4'd12;
  localparam logic [3:0] OP_JN    = 4'd13;

  // Bit positions inside the {C,N,Z} flag register.
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_IRLD  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_DIVW  = 3'd4,
    ST_HALT  = 3'd5
  } state_t;

  // Opcodes that read or write the RAM word addressed by the operand field.
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op <= OP_DIV) || (op == OP_AND) || (op == OP_OR);
  endfunction

endpackage

// File: rtl/fbcpu_divider.sv
// Unsigned restoring divider, one quotient bit per clock.
// Handshake: start is sampled only while busy is low; the operands are captured on
// that edge. busy stays high for exactly DATA_W cycles and done pulses high in the
// last of them, with quotient/remainder valid (combinationally) during that cycle
// only. rst drops busy immediately, abandoning any divide in flight.
module fbcpu_divider #(
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  localparam int CW = $clog2(DATA_W + 1);

  logic              busy_q;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] quo_q, rem_q, dvs_q;
  logic [DATA_W:0]   rem_sh, diff;
  logic              q_bit;
  logic [DATA_W-1:0] quo_nx, rem_nx;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_sh = {rem_q, quo_q[DATA_W-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    q_bit  = ~diff[DATA_W];
    rem_nx = q_bit ? diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];
    quo_nx = {quo_q[DATA_W-2:0], q_bit};
  end

  // Iteration registers; the quotient shifts in from the bottom as the dividend shifts out.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
    end else if (start && !busy_q) begin
      busy_q <= 1'b1;
      cnt_q  <= CW'(DATA_W);
      quo_q  <= dividend;
      rem_q  <= '0;
      dvs_q  <= divisor;
    end else if (busy_q) begin
      quo_q <= quo_nx;
      rem_q <= rem_nx;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_q <= 1'b0;
    end
  end

  assign busy      = busy_q;
  assign done      = busy_q && (cnt_q == CW'(1));
  assign quotient  = quo_nx;
  assign remainder = rem_nx;

endmodule

// File: rtl/fbcpu_acc_core.sv
// FB-CPU accumulator core: fetch / decode / execute FSM over a single-port RAM,
// with Z/N/C flags, an iterative divider and a resumable HALT state.
// DATA_W must be at least ADDR_W+4 so the opcode and operand fields do not overlap.
module fbcpu_acc_core
  import fbcpu_pkg::*;
#(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 10,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              resume,
  input  logic [DATA_W-1:0] MDROut,
  output logic [DATA_W-1:0] MDRIn,
  output logic              RAMWr,
  output logic [ADDR_W-1:0] MAR,
  output logic [ADDR_W-1:0] PC,
  output logic [DATA_W-1:0] ACC,
  output logic [2:0]        flags,
  output logic              halted,
  output logic              div0_err,
  output state_t            dbg_state_o
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [2:0]        flags_q, flags_d;
  logic              div0_q, div0_d;

  logic [ADDR_W-1:0] mar_c;
  logic              ramwr_c;
  logic [DATA_W-1:0] mdrin_c;
  logic              wr_acc, carry, div_start;

  logic [3:0]          op;
  logic [ADDR_W-1:0]   operand;
  logic [DATA_W-1:0]   imm;
  logic [DATA_W:0]     sum;
  logic [2*DATA_W-1:0] prod;

  logic              div_done;
  logic [DATA_W-1:0] div_quo;
  logic [DATA_W-1:0] div_rem_unused;
  logic              div_busy_unused;

  assign op      = ir_q[DATA_W-1 -: 4];
  assign operand = ir_q[ADDR_W-1:0];
  assign imm     = {4'b0000, ir_q[DATA_W-5:0]};
  assign sum     = {1'b0, acc_q} + {1'b0, MDROut};
  assign prod    = {{DATA_W{1'b0}}, acc_q} * {{DATA_W{1'b0}}, MDROut};

  fbcpu_divider #(.DATA_W(DATA_W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (acc_q),
    .divisor   (MDROut),
    .busy      (div_busy_unused),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem_unused)
  );

  // Next-state, datapath updates and RAM strobes; flags follow any ACC write.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    acc_d     = acc_q;
    flags_d   = flags_q;
    div0_d    = div0_q;
    mar_c     = '0;
    ramwr_c   = 1'b0;
    mdrin_c   = '0;
    wr_acc    = 1'b0;
    carry     = 1'b0;
    div_start = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mar_c   = pc_q;
        state_d = ST_IRLD;
      end
      ST_IRLD: begin
        ir_d    = MDROut;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        if (is_mem_op(op)) begin
          mar_c   = operand;
          state_d = ST_MEM;
        end else begin
          case (op)
            OP_JMP:  pc_d = operand;
            OP_JZ:   if (flags_q[FLAG_Z]) pc_d = operand;
            OP_JN:   if (flags_q[FLAG_N]) pc_d = operand;
            OP_LDI:  begin acc_d = imm; wr_acc = 1'b1; end
            OP_HALT: state_d = ST_HALT;
            default: ;
          endcase
        end
      end
      ST_MEM: begin
        state_d = ST_FETCH;
        case (op)
          OP_LOAD:  begin acc_d = MDROut; wr_acc = 1'b1; end
          OP_STORE: begin
            mar_c   = operand;
            ramwr_c = 1'b1;
            mdrin_c = acc_q;
          end
          OP_ADD:   begin acc_d = sum[DATA_W-1:0]; carry = sum[DATA_W]; wr_acc = 1'b1; end
          OP_SUB:   begin acc_d = acc_q - MDROut; carry = (acc_q < MDROut); wr_acc = 1'b1; end
          OP_MUL:   begin acc_d = prod[DATA_W-1:0]; carry = |prod[2*DATA_W-1:DATA_W]; wr_acc = 1'b1; end
          OP_AND:   begin acc_d = acc_q & MDROut; wr_acc = 1'b1; end
          OP_OR:    begin acc_d = acc_q | MDROut; wr_acc = 1'b1; end
          OP_DIV: begin
            if (MDROut == '0) begin
              acc_d  = '1;
              carry  = 1'b1;
              wr_acc = 1'b1;
              div0_d = 1'b1;
            end else begin
              div_start = 1'b1;
              state_d   = ST_DIVW;
            end
          end
          default: ;
        endcase
      end
      ST_DIVW: begin
        if (div_done) begin
          acc_d   = div_quo;
          wr_acc  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_HALT: begin
        if (resume) state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
    if (wr_acc) begin
      flags_d[FLAG_Z] = (acc_d == '0);
      flags_d[FLAG_N] = acc_d[DATA_W-1];
      flags_d[FLAG_C] = carry;
    end
  end

  // Architectural state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      pc_q    <= ADDR_W'(RESET_PC);
      ir_q    <= '0;
      acc_q   <= '0;
      flags_q <= '0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      flags_q <= flags_d;
      div0_q  <= div0_d;
    end
  end

  // RAM strobes are forced quiet while reset is held.
  assign MAR         = rst ? '0 : mar_c;
  assign RAMWr       = rst ? 1'b0 : ramwr_c;
  assign MDRIn       = rst ? '0 : mdrin_c;
  assign PC          = pc_q;
  assign ACC         = acc_q;
  assign flags       = flags_q;
  assign halted      = (state_q == ST_HALT);
  assign div0_err    = div0_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fbcpu_acc_core.sv
// Directed bench for fbcpu_acc_core with a synchronous-read RAM model.
module tb_fbcpu_acc_core;
  import fbcpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       resume = 1'b0;
  logic [9:0] mdr_q;
  logic [9:0] mdrin;
  logic       ramwr;
  logic [5:0] mar;
  logic [5:0] pc;
  logic [9:0] acc;
  logic [2:0] flags;
  logic       halted;
  logic       div0_err;
  state_t     dbg_state;

  logic       ld_we = 1'b0;
  logic [5:0] ld_addr = '0;
  logic [9:0] ld_data = '0;
  logic [9:0] ram [64];

  int errors = 0;
  int checks = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  fbcpu_acc_core #(.ADDR_W(6), .DATA_W(10), .RESET_PC(0)) dut (
    .clk         (clk),
    .rst         (rst),
    .resume      (resume),
    .MDROut      (mdr_q),
    .MDRIn       (mdrin),
    .RAMWr       (ramwr),
    .MAR         (mar),
    .PC          (pc),
    .ACC         (acc),
    .flags       (flags),
    .halted      (halted),
    .div0_err    (div0_err),
    .dbg_state_o (dbg_state)
  );

  // RAM model: bench loader port has priority, read data appears one cycle after MAR.
  always_ff @(posedge clk) begin
    if (ld_we) ram[ld_addr] <= ld_data;
    else if (ramwr) ram[mar] <= mdrin;
    mdr_q <= ram[mar];
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hold_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic load_word(input int a, input int d);
    ld_we   = 1'b1;
    ld_addr = 6'(a);
    ld_data = 10'(d);
    @(negedge clk);
    ld_we   = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    hold_reset();
    for (int a = 0; a < 64; a++) load_word(a, 0);
    checks++; if (pc !== 6'd0) begin errors++; $display("FAIL reset_pc: got %0d expected 0", pc); end
    checks++; if (acc !== 10'd0) begin errors++; $display("FAIL reset_acc: got %0d expected 0", acc); end
    checks++; if (flags !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", flags); end
    checks++; if (dbg_state !== ST_FETCH) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_FETCH); end
    checks++; if ({mar, ramwr, mdrin} !== 17'd0) begin errors++; $display("FAIL reset_ram_if: got mar=%0d wr=%0b din=%0d expected all 0", mar, ramwr, mdrin); end
    checks++; if ({halted, div0_err} !== 2'b00) begin errors++; $display("FAIL reset_status: got %b expected 00", {halted, div0_err}); end
  endtask

  task automatic test_add_store();
    int wr_cnt;
    hold_reset();
    load_word(0, 773);  // LDI 5
    load_word(1, 148);  // ADD [20]
    load_word(2, 85);   // STORE 21
    load_word(3, 576);  // HALT
    load_word(20, 3);
    load_word(21, 0);
    rst = 1'b0;         // t=0
    step(3);            // t=3
    checks++; if (acc !== 10'd5 || pc !== 6'd1 || dbg_state !== ST_FETCH) begin errors++; $display("FAIL ldi_timing: got acc=%0d pc=%0d st=%0d expected acc=5 pc=1 st=0", acc, pc, dbg_state); end
    step(3);            // t=6, ADD in MEM
    checks++; if (acc !== 10'd5) begin errors++; $display("FAIL add_mem_cycle: got acc=%0d expected 5", acc); end
    step(1);            // t=7
    checks++; if (acc !== 10'd8 || flags !== 3'b000 || pc !== 6'd2) begin errors++; $display("FAIL add_result: got acc=%0d flags=%b pc=%0d expected 8 000 2", acc, flags, pc); end
    wr_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (ramwr) begin
        wr_cnt++;
        checks++; if (mar !== 6'd21 || mdrin !== 10'd8 || i != 3) begin errors++; $display("FAIL store_strobe: got mar=%0d din=%0d cycle=%0d expected 21 8 3", mar, mdrin, i); end
      end
      step(1);
    end                 // t=11
    checks++; if (wr_cnt != 1) begin errors++; $display("FAIL store_wr_count: got %0d expected 1", wr_cnt); end
    checks++; if (ram[21] !== 10'd8) begin errors++; $display("FAIL store_ram: got %0d expected 8", ram[21]); end
    checks++; if (flags !== 3'b000 || dbg_state !== ST_FETCH) begin errors++; $display("FAIL store_flags: got flags=%b st=%0d expected 000 0", flags, dbg_state); end
    step(3);            // t=14
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_after_store: got %0b expected 1", halted); end
  endtask

  task automatic test_sub_jumps();
    hold_reset();
    load_word(0, 770);  // LDI 2
    load_word(1, 212);  // SUB [20]
    load_word(2, 872);  // JN 40
    load_word(40, 498); // JZ 50
    load_word(41, 576); // HALT
    load_word(20, 3);
    rst = 1'b0;
    step(7);            // t=7
    checks++; if (acc !== 10'h3FF || flags !== 3'b110) begin errors++; $display("FAIL sub_borrow: got acc=%0h flags=%b expected 3ff 110", acc, flags); end
    step(3);            // t=10
    checks++; if (pc !== 6'd40 || dbg_state !== ST_FETCH) begin errors++; $display("FAIL jn_taken: got pc=%0d st=%0d expected 40 0", pc, dbg_state); end
    step(3);            // t=13
    checks++; if (pc !== 6'd41 || flags !== 3'b110) begin errors++; $display("FAIL jz_not_taken: got pc=%0d flags=%b expected 41 110", pc, flags); end
  endtask

  task automatic test_div();
    hold_reset();
    load_word(0, 20);   // LOAD [20]
    load_word(1, 341);  // DIV [21]
    load_word(2, 342);  // DIV [22]
    load_word(3, 576);  // HALT
    load_word(20, 100);
    load_word(21, 7);
    load_word(22, 0);
    rst = 1'b0;
    step(4);            // t=4
    checks++; if (acc !== 10'd100) begin errors++; $display("FAIL load: got %0d expected 100", acc); end
    step(13);           // t=17, last DIVW cycle
    checks++; if (dbg_state !== ST_DIVW || acc !== 10'd100) begin errors++; $display("FAIL div_busy: got st=%0d acc=%0d expected 4 100", dbg_state, acc); end
    step(1);            // t=18
    checks++; if (acc !== 10'd14 || flags !== 3'b000 || dbg_state !== ST_FETCH) begin errors++; $display("FAIL div_result: got acc=%0d flags=%b st=%0d expected 14 000 0", acc, flags, dbg_state); end
    step(4);            // t=22
    checks++; if (acc !== 10'h3FF || flags !== 3'b110 || div0_err !== 1'b1) begin errors++; $display("FAIL div0: got acc=%0h flags=%b err=%0b expected 3ff 110 1", acc, flags, div0_err); end
    step(3);            // t=25
    checks++; if (halted !== 1'b1 || div0_err !== 1'b1) begin errors++; $display("FAIL div0_sticky: got halted=%0b err=%0b expected 1 1", halted, div0_err); end
  endtask

  task automatic test_mul_wrap();
    hold_reset();
    load_word(0, 808);  // LDI 40
    load_word(1, 276);  // MUL [20]
    load_word(2, 447);  // JMP 63
    load_word(63, 512); // NOP
    load_word(20, 40);
    rst = 1'b0;
    step(7);            // t=7
    checks++; if (acc !== 10'd576 || flags !== 3'b110) begin errors++; $display("FAIL mul: got acc=%0d flags=%b expected 576 110", acc, flags); end
    step(3);            // t=10
    checks++; if (pc !== 6'd63) begin errors++; $display("FAIL jmp: got pc=%0d expected 63", pc); end
    step(3);            // t=13
    checks++; if (pc !== 6'd0 || dbg_state !== ST_FETCH || flags !== 3'b110) begin errors++; $display("FAIL pc_wrap: got pc=%0d st=%0d flags=%b expected 0 0 110", pc, dbg_state, flags); end
  endtask

  task automatic test_logic_carry();
    hold_reset();
    load_word(0, 813);  // LDI 45
    load_word(1, 660);  // AND [20]
    load_word(2, 725);  // OR [21]
    load_word(3, 150);  // ADD [22]
    load_word(4, 478);  // JZ 30
    load_word(20, 54);
    load_word(21, 768);
    load_word(22, 220);
    rst = 1'b0;
    step(7);            // t=7
    checks++; if (acc !== 10'd36 || flags !== 3'b000) begin errors++; $display("FAIL and: got acc=%0d flags=%b expected 36 000", acc, flags); end
    step(4);            // t=11
    checks++; if (acc !== 10'd804 || flags !== 3'b010) begin errors++; $display("FAIL or: got acc=%0d flags=%b expected 804 010", acc, flags); end
    step(4);            // t=15
    checks++; if (acc !== 10'd0 || flags !== 3'b101) begin errors++; $display("FAIL add_carry: got acc=%0d flags=%b expected 0 101", acc, flags); end
    step(3);            // t=18
    checks++; if (pc !== 6'd30) begin errors++; $display("FAIL jz_taken: got pc=%0d expected 30", pc); end
  endtask

  task automatic test_halt_resume();
    hold_reset();
    for (int a = 0; a < 5; a++) load_word(a, 512);  // NOPs
    load_word(5, 576);  // HALT
    load_word(6, 775);  // LDI 7
    load_word(7, 576);  // HALT
    rst = 1'b0;
    step(18);           // t=18
    checks++; if (halted !== 1'b1 || pc !== 6'd6 || dbg_state !== ST_HALT) begin errors++; $display("FAIL halt_enter: got halted=%0b pc=%0d st=%0d expected 1 6 5", halted, pc, dbg_state); end
    for (int i = 0; i < 10; i++) begin
      checks++; if (mar !== 6'd0 || ramwr !== 1'b0 || halted !== 1'b1) begin errors++; $display("FAIL halt_idle: got mar=%0d wr=%0b halted=%0b expected 0 0 1", mar, ramwr, halted); end
      step(1);
    end                 // t=28
    resume = 1'b1;
    step(1);            // t=29
    resume = 1'b0;
    checks++; if (dbg_state !== ST_FETCH || mar !== 6'd6 || halted !== 1'b0) begin errors++; $display("FAIL resume: got st=%0d mar=%0d halted=%0b expected 0 6 0", dbg_state, mar, halted); end
    resume = 1'b1;      // ignored outside HALT
    step(1);            // t=30
    resume = 1'b0;
    checks++; if (dbg_state !== ST_IRLD) begin errors++; $display("FAIL resume_ignored: got st=%0d expected 1", dbg_state); end
    step(2);            // t=32
    checks++; if (acc !== 10'd7 || pc !== 6'd7) begin errors++; $display("FAIL after_resume: got acc=%0d pc=%0d expected 7 7", acc, pc); end
  endtask

  task automatic test_reset_mid_div();
    hold_reset();
    load_word(0, 22);   // LOAD [22]
    load_word(1, 341);  // DIV [21]
    load_word(22, 1000);
    load_word(21, 7);
    rst = 1'b0;
    checks++; if (div0_err !== 1'b0) begin errors++; $display("FAIL div0_cleared: got %0b expected 0", div0_err); end
    step(4);            // t=4
    checks++; if (acc !== 10'd1000 || flags !== 3'b010) begin errors++; $display("FAIL load_neg: got acc=%0d flags=%b expected 1000 010", acc, flags); end
    step(6);            // t=10, third DIVW cycle
    checks++; if (dbg_state !== ST_DIVW) begin errors++; $display("FAIL in_divw: got st=%0d expected 4", dbg_state); end
    rst = 1'b1;
    step(1);            // t=11
    checks++; if (pc !== 6'd0 || acc !== 10'd0 || flags !== 3'b000 || dbg_state !== ST_FETCH) begin errors++; $display("FAIL mid_div_reset: got pc=%0d acc=%0d flags=%b st=%0d expected 0 0 000 0", pc, acc, flags, dbg_state); end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (acc !== 10'd0) begin errors++; $display("FAIL stale_div: got acc=%0d expected 0", acc); end
      step(1);
    end                 // t=15
    checks++; if (acc !== 10'd1000) begin errors++; $display("FAIL rerun_load: got %0d expected 1000", acc); end
    step(14);           // t=29
    checks++; if (acc !== 10'd142 || flags !== 3'b000) begin errors++; $display("FAIL rerun_div: got acc=%0d flags=%b expected 142 000", acc, flags); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_add_store();
    test_sub_jumps();
    test_div();
    test_mul_wrap();
    test_logic_carry();
    test_halt_resume();
    test_reset_mid_div();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
